// File: rtl/shift_mode_pkg.sv
`default_nettype none
// ============================================================================
// shift_mode_pkg : operation encodings shared by the shift register and benches
// Revision 1.0
// ============================================================================
package shift_mode_pkg;

  typedef logic [2:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD  = 3'd0;
  localparam shift_mode_t MODE_SHR   = 3'd1;
  localparam shift_mode_t MODE_SHL   = 3'd2;
  localparam shift_mode_t MODE_ROR   = 3'd3;
  localparam shift_mode_t MODE_ROL   = 3'd4;
  localparam shift_mode_t MODE_LOAD  = 3'd5;
  localparam shift_mode_t MODE_CLEAR = 3'd6;
  localparam shift_mode_t MODE_ASR   = 3'd7;

  // Modes that move bits and therefore advance the frame counter.
  function automatic logic is_shift_mode(input shift_mode_t mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

  function automatic logic is_reload_mode(input shift_mode_t mode);
    return (mode == MODE_LOAD) || (mode == MODE_CLEAR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_frame_counter.sv
`default_nettype none
// ============================================================================
// shift_frame_counter : modulo-WIDTH shift counter with registered frame pulse
// Revision 1.0
// ============================================================================
module shift_frame_counter #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] cnt,
  output logic                     frame_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;

  // Explicit wrap at WIDTH-1 so non-power-of-two widths count correctly.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = done_q;

endmodule
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// univ_shift_reg : universal shift register (shift/rotate/load/clear/ASR)
// Revision 1.0
// ============================================================================
module univ_shift_reg
  import shift_mode_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic [WIDTH-1:0]         d,
  input  logic                     sin_l,
  input  logic                     sin_r,
  output logic [WIDTH-1:0]         q,
  output logic                     sout_r,
  output logic                     sout_l,
  output logic [$clog2(WIDTH)-1:0] shift_cnt,
  output logic                     frame_done
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             cnt_inc, cnt_clr;

  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        MODE_SHR:   q_d = {sin_l, q_q[WIDTH-1:1]};
        MODE_SHL:   q_d = {q_q[WIDTH-2:0], sin_r};
        MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_LOAD:  q_d = d;
        MODE_CLEAR: q_d = '0;
        MODE_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        default:    q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign cnt_inc = en & is_shift_mode(mode);
  assign cnt_clr = en & is_reload_mode(mode);

  shift_frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk        (clk),
    .reset      (reset),
    .inc        (cnt_inc),
    .clr        (cnt_clr),
    .cnt        (shift_cnt),
    .frame_done (frame_done)
  );

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];

endmodule
`default_nettype wire
